// File: rtl/traffic_phase_scheduler.sv
// Phase timing and emergency arbitration front-end for the four-phase traffic light FSM.
// Produces the green/yellow expiry strobes, pedestrian green extension and one-hot emergency grants.
module traffic_phase_scheduler #(
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int PED_EXT  = 5,
  parameter int EMG_HOLD = 8,
  parameter int CNT_W    = 5
) (
  input  logic             clk_1hz,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic             emg_req_a,
  input  logic             emg_req_b,
  input  logic             ped_req_a,
  input  logic             ped_req_b,
  output logic             time1,
  output logic             time2,
  output logic             emergency_A,
  output logic             emergency_B,
  output logic             ped_walk_a,
  output logic             ped_walk_b,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;

  localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] PED_C    = CNT_W'(PED_EXT);
  localparam logic [CNT_W-1:0] EMG_C    = CNT_W'(EMG_HOLD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

  logic [2:0]       prev_state_q;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  grant_e           grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             ped_a_q, ped_a_d, ped_b_q, ped_b_d;
  logic             ext_s0_q, ext_s0_d, ext_s2_q, ext_s2_d;

  logic             validState, phaseEntry, grantActive;
  logic             inS0, inS2, inYellow;
  logic             extS0, extS2;
  logic [CNT_W-1:0] cntNow, greenLast, holdInc;

  // The first cycle of a phase reads 0 even though the stored count still holds the old phase,
  // so a phase whose strobe fires at count N-1 lasts exactly N cycles.
  always_comb begin
    validState  = (state[2] == 1'b0);
    phaseEntry  = (state != prev_state_q);
    grantActive = (grant_q != GRANT_IDLE);
    inS0        = (state == S0);
    inS2        = (state == S2);
    inYellow    = (state == S1) || (state == S3);

    cntNow = (phaseEntry || grantActive || !validState) ? '0 : phase_cnt_q;

    extS0    = (inS0 && phaseEntry) ? ped_b_q : ext_s0_q;
    extS2    = (inS2 && phaseEntry) ? ped_a_q : ext_s2_q;
    ext_s0_d = extS0;
    ext_s2_d = extS2;

    greenLast = ((inS2 ? extS2 : extS0) ? (GREEN_C + PED_C) : GREEN_C) - ONE_C;

    if (grantActive || !validState)
      phase_cnt_d = '0;
    else if (phaseEntry)
      phase_cnt_d = ONE_C;
    else if (phase_cnt_q != CNT_MAX)
      phase_cnt_d = phase_cnt_q + ONE_C;
    else
      phase_cnt_d = phase_cnt_q;

    // A latch is cleared one edge after its serving phase ends; a new press on that edge still wins.
    if (ped_req_a && !inS2)
      ped_a_d = 1'b1;
    else if ((prev_state_q == S2) && !inS2)
      ped_a_d = 1'b0;
    else
      ped_a_d = ped_a_q | ped_req_a;

    if (ped_req_b && !inS0)
      ped_b_d = 1'b1;
    else if ((prev_state_q == S0) && !inS0)
      ped_b_d = 1'b0;
    else
      ped_b_d = ped_b_q | ped_req_b;
  end

  // Grant arbitration: contested requests from idle go to the pointer's road, an active grant
  // is never preempted, and the hold count includes the cycle it is evaluated in.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    holdInc = (hold_q < EMG_C) ? (hold_q + ONE_C) : hold_q;

    case (grant_q)
      GRANT_IDLE: begin
        if (emg_req_a && emg_req_b) begin
          grant_d = ptr_q ? GRANT_B : GRANT_A;
          ptr_d   = ~ptr_q;
          hold_d  = '0;
        end else if (emg_req_a) begin
          grant_d = GRANT_A;
          hold_d  = '0;
        end else if (emg_req_b) begin
          grant_d = GRANT_B;
          hold_d  = '0;
        end
      end
      GRANT_A: begin
        hold_d = holdInc;
        if (!emg_req_a && (holdInc >= EMG_C)) begin
          grant_d = emg_req_b ? GRANT_B : GRANT_IDLE;
          hold_d  = '0;
        end
      end
      GRANT_B: begin
        hold_d = holdInc;
        if (!emg_req_b && (holdInc >= EMG_C)) begin
          grant_d = emg_req_a ? GRANT_A : GRANT_IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        grant_d = GRANT_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      prev_state_q <= S0;
      phase_cnt_q  <= '0;
      grant_q      <= GRANT_IDLE;
      ptr_q        <= 1'b0;
      hold_q       <= '0;
      ped_a_q      <= 1'b0;
      ped_b_q      <= 1'b0;
      ext_s0_q     <= 1'b0;
      ext_s2_q     <= 1'b0;
    end else begin
      prev_state_q <= state;
      phase_cnt_q  <= phase_cnt_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      ped_a_q      <= ped_a_d;
      ped_b_q      <= ped_b_d;
      ext_s0_q     <= ext_s0_d;
      ext_s2_q     <= ext_s2_d;
    end
  end

  assign time1       = !rst && (inS0 || inS2) && !grantActive && (cntNow >= greenLast);
  assign time2       = !rst && inYellow && !grantActive && (cntNow >= (YELLOW_C - ONE_C));
  assign ped_walk_a  = !rst && inS2 && extS2;
  assign ped_walk_b  = !rst && inS0 && extS0;
  assign phase_cnt   = cntNow;
  assign emergency_A = (grant_q == GRANT_A);
  assign emergency_B = (grant_q == GRANT_B);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler; a small FSM model closes the loop on the state input.
module tb_traffic_phase_scheduler;

  logic       clk_1hz = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       emg_req_a, emg_req_b, ped_req_a, ped_req_b;
  logic       time1, time2, emergency_A, emergency_B, ped_walk_a, ped_walk_b;
  logic [4:0] phase_cnt;
  bit         autoFsm;
  int         checks = 0;
  int         passes = 0;

  traffic_phase_scheduler dut (
    .clk_1hz    (clk_1hz),
    .rst        (rst),
    .state      (state),
    .emg_req_a  (emg_req_a),
    .emg_req_b  (emg_req_b),
    .ped_req_a  (ped_req_a),
    .ped_req_b  (ped_req_b),
    .time1      (time1),
    .time2      (time2),
    .emergency_A(emergency_A),
    .emergency_B(emergency_B),
    .ped_walk_a (ped_walk_a),
    .ped_walk_b (ped_walk_b),
    .phase_cnt  (phase_cnt)
  );

  always #5 clk_1hz = ~clk_1hz;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [2:0] fsmNext(input logic [2:0] s, input logic t1, input logic t2,
                                         input logic eA, input logic eB);
    if (eA) return 3'd0;
    if (eB) return 3'd2;
    case (s)
      3'd0: return t1 ? 3'd1 : 3'd0;
      3'd1: return t2 ? 3'd2 : 3'd1;
      3'd2: return t1 ? 3'd3 : 3'd2;
      3'd3: return t2 ? 3'd0 : 3'd3;
      default: return s;
    endcase
  endfunction

  // One clock: the FSM model reacts to the strobes seen before the edge, outputs settle by edge+2.
  task automatic tick();
    logic t1, t2, eA, eB;
    t1 = time1; t2 = time2; eA = emergency_A; eB = emergency_B;
    @(posedge clk_1hz);
    #1;
    if (autoFsm) state = fsmNext(state, t1, t2, eA, eB);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; state = 3'd0; autoFsm = 1'b1;
    emg_req_a = 1'b0; emg_req_b = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0;
    repeat (2) @(posedge clk_1hz);
    #2 rst = 1'b0;
  endtask

  task automatic waitState(input logic [2:0] s, output int n);
    n = 0;
    while (state !== s && n < 60) begin tick(); n++; end
  endtask

  task automatic measureS2(output int len, output int walk, output int lastCnt);
    len = 0; walk = 0; lastCnt = -1;
    while (state === 3'd2 && len < 40) begin
      len++;
      if (ped_walk_a) walk++;
      if (time1) lastCnt = int'(phase_cnt);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 3'd0; autoFsm = 1'b1;
    emg_req_a = 1'b0; emg_req_b = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0;
    repeat (2) @(posedge clk_1hz);
    #2;
    checks++;
    if ({time1, time2, emergency_A, emergency_B, ped_walk_a, ped_walk_b, phase_cnt} !== 11'd0)
      $display("[TB] FAIL reset_outputs: got %b, want all zero",
               {time1, time2, emergency_A, emergency_B, ped_walk_a, ped_walk_b, phase_cnt});
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if (phase_cnt !== 5'd1 || time1 !== 1'b0)
      $display("[TB] FAIL post_reset_count: got cnt=%0d time1=%b, want 1/0", phase_cnt, time1);
    else passes++;
  endtask

  task automatic test_default_cycle();
    int strobes;
    doReset();
    strobes = 0;
    for (int i = 0; i <= 26; i++) begin
      if (time1 || time2) strobes++;
      if (i == 8) begin
        checks++;
        if (time1 !== 1'b0) $display("[TB] FAIL s0_early: got time1=%b at cnt=%0d, want 0", time1, phase_cnt);
        else passes++;
      end
      if (i == 9) begin
        checks++;
        if ({time1, state, phase_cnt} !== {1'b1, 3'd0, 5'd9})
          $display("[TB] FAIL s0_expiry: got time1=%b state=%0d cnt=%0d, want 1/0/9", time1, state, phase_cnt);
        else passes++;
      end
      if (i == 12) begin
        checks++;
        if ({time2, state, phase_cnt} !== {1'b1, 3'd1, 5'd2})
          $display("[TB] FAIL s1_expiry: got time2=%b state=%0d cnt=%0d, want 1/1/2", time2, state, phase_cnt);
        else passes++;
      end
      if (i == 22) begin
        checks++;
        if ({time1, state, phase_cnt} !== {1'b1, 3'd2, 5'd9})
          $display("[TB] FAIL s2_expiry: got time1=%b state=%0d cnt=%0d, want 1/2/9", time1, state, phase_cnt);
        else passes++;
      end
      if (i == 25) begin
        checks++;
        if ({time2, state, phase_cnt} !== {1'b1, 3'd3, 5'd2})
          $display("[TB] FAIL s3_expiry: got time2=%b state=%0d cnt=%0d, want 1/3/2", time2, state, phase_cnt);
        else passes++;
      end
      if (i < 26) tick();
    end
    checks++;
    if ({state, phase_cnt, time1} !== {3'd0, 5'd0, 1'b0})
      $display("[TB] FAIL cycle_wrap: got state=%0d cnt=%0d time1=%b after 26 cycles, want 0/0/0", state, phase_cnt, time1);
    else passes++;
    checks++;
    if (strobes != 4) $display("[TB] FAIL strobe_count: got %0d strobes in one cycle, want 4", strobes);
    else passes++;
  endtask

  task automatic test_ped_extension();
    int n, len, walk, lastCnt;
    ped_req_a = 1'b1;
    tick();
    ped_req_a = 1'b0;
    waitState(3'd2, n);
    checks++;
    if (n >= 60) $display("[TB] FAIL ped_wait_s2: timed out after %0d cycles, want S2", n);
    else passes++;
    measureS2(len, walk, lastCnt);
    checks++;
    if (len != 15 || walk != 15 || lastCnt != 14)
      $display("[TB] FAIL ped_extended_green: got len=%0d walk=%0d t1cnt=%0d, want 15/15/14", len, walk, lastCnt);
    else passes++;
    checks++;
    if (ped_walk_a !== 1'b0 || state !== 3'd3)
      $display("[TB] FAIL ped_walk_off: got walk=%b state=%0d, want 0/3", ped_walk_a, state);
    else passes++;
    waitState(3'd2, n);
    measureS2(len, walk, lastCnt);
    checks++;
    if (len != 10 || walk != 0 || lastCnt != 9)
      $display("[TB] FAIL ped_latch_cleared: got len=%0d walk=%0d t1cnt=%0d, want 10/0/9", len, walk, lastCnt);
    else passes++;
  endtask

  task automatic test_emergency_b();
    int n, gc, bad, len, walk, lastCnt;
    n = 0;
    while (!(state === 3'd0 && phase_cnt === 5'd4) && n < 60) begin tick(); n++; end
    checks++;
    if (n >= 60) $display("[TB] FAIL emg_wait_s0: timed out, state=%0d cnt=%0d", state, phase_cnt);
    else passes++;
    emg_req_b = 1'b1;
    tick();
    checks++;
    if ({emergency_A, emergency_B, time1, phase_cnt} !== {1'b0, 1'b1, 1'b0, 5'd0})
      $display("[TB] FAIL emg_b_grant: got A=%b B=%b time1=%b cnt=%0d, want 0/1/0/0",
               emergency_A, emergency_B, time1, phase_cnt);
    else passes++;
    gc = 0; bad = 0;
    while (emergency_B === 1'b1 && gc < 20) begin
      gc++;
      if (time1 || time2 || phase_cnt != 5'd0 || emergency_A) bad++;
      if (gc == 2) emg_req_b = 1'b0;
      tick();
    end
    checks++;
    if (gc != 8 || bad != 0)
      $display("[TB] FAIL emg_b_hold: got %0d grant cycles with %0d bad, want 8/0", gc, bad);
    else passes++;
    checks++;
    if ({state, phase_cnt, emergency_A, emergency_B} !== {3'd2, 5'd0, 1'b0, 1'b0})
      $display("[TB] FAIL emg_b_release: got state=%0d cnt=%0d A=%b B=%b, want 2/0/0/0",
               state, phase_cnt, emergency_A, emergency_B);
    else passes++;
    measureS2(len, walk, lastCnt);
    checks++;
    if (len != 10 || lastCnt != 9)
      $display("[TB] FAIL emg_b_full_green: got len=%0d t1cnt=%0d, want 10/9", len, lastCnt);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int n, both;
    doReset();
    emg_req_a = 1'b1; emg_req_b = 1'b1;
    tick();
    checks++;
    if ({emergency_A, emergency_B} !== 2'b10)
      $display("[TB] FAIL contest_first: got A=%b B=%b, want 1/0", emergency_A, emergency_B);
    else passes++;
    n = 0; both = 0;
    while (emergency_A === 1'b1 && n < 20) begin
      n++;
      if (emergency_B) both++;
      if (n == 3) emg_req_a = 1'b0;
      tick();
    end
    checks++;
    if (n != 8 || both != 0 || {emergency_A, emergency_B} !== 2'b01)
      $display("[TB] FAIL direct_handover: got A-cycles=%0d overlap=%0d A=%b B=%b, want 8/0/0/1",
               n, both, emergency_A, emergency_B);
    else passes++;
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({time1, time2, emergency_A, emergency_B, ped_walk_a, ped_walk_b, phase_cnt} !== 11'd0)
      $display("[TB] FAIL async_reset: got %b, want all zero",
               {time1, time2, emergency_A, emergency_B, ped_walk_a, ped_walk_b, phase_cnt});
    else passes++;
    state = 3'd0; emg_req_a = 1'b0; emg_req_b = 1'b0;
    @(posedge clk_1hz);
    #2 rst = 1'b0;
    emg_req_a = 1'b1; emg_req_b = 1'b1;
    tick();
    checks++;
    if ({emergency_A, emergency_B} !== 2'b10)
      $display("[TB] FAIL pointer_reset: got A=%b B=%b, want 1/0", emergency_A, emergency_B);
    else passes++;
  endtask

  task automatic test_round_robin();
    int n;
    emg_req_a = 1'b0; emg_req_b = 1'b0;
    n = 0;
    while ((emergency_A || emergency_B) && n < 20) begin tick(); n++; end
    emg_req_a = 1'b1; emg_req_b = 1'b1;
    tick();
    checks++;
    if ({emergency_A, emergency_B} !== 2'b01 || n >= 20)
      $display("[TB] FAIL round_robin: got A=%b B=%b idle-wait=%0d, want 0/1 within 20", emergency_A, emergency_B, n);
    else passes++;
  endtask

  task automatic test_invalid_state();
    int n;
    emg_req_a = 1'b0; emg_req_b = 1'b0;
    n = 0;
    while ((emergency_A || emergency_B) && n < 20) begin tick(); n++; end
    autoFsm = 1'b0;
    state = 3'd5;
    #1;
    tick(); tick(); tick();
    checks++;
    if ({time1, time2, ped_walk_a, ped_walk_b, phase_cnt} !== 9'd0 || n >= 20)
      $display("[TB] FAIL invalid_state: got t1=%b t2=%b walk=%b%b cnt=%0d wait=%0d, want all zero",
               time1, time2, ped_walk_a, ped_walk_b, phase_cnt, n);
    else passes++;
    checks++;
    if ($isunknown({time1, time2, emergency_A, emergency_B, ped_walk_a, ped_walk_b, phase_cnt}))
      $display("[TB] FAIL invalid_no_x: got %b, want no X/Z",
               {time1, time2, emergency_A, emergency_B, ped_walk_a, ped_walk_b, phase_cnt});
    else passes++;
    state = 3'd0;
    #1;
    tick();
    checks++;
    if (phase_cnt !== 5'd1)
      $display("[TB] FAIL invalid_recover: got cnt=%0d one cycle after S0, want 1", phase_cnt);
    else passes++;
    autoFsm = 1'b1;
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_ped_extension();
    test_emergency_b();
    test_back_to_back();
    test_round_robin();
    test_invalid_state();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
